adxl_spi_responder: RTL

SPI mode-0 responder that emulates the ADXL362 register-access protocol (0x0A write, 0x0B read, with address auto-increment) over a byte-wide register file. It is the far end of the MMIO SPI master. In simulation and loop-back builds it stands in for the accelerometer. The local side lets a testbench or sensor model preload registers and observe SPI-side writes. All SPI inputs are oversampled in the `clk` domain; there is no SCLK clock domain.

---
 rtl/adxl_spi_responder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/adxl_spi_responder.sv
// SPI mode-0 responder emulating the ADXL362 0x0A write / 0x0B read register protocol.
// Optional macro SPI_RESP_RO_PROTECT_EN makes addresses below RO_LIMIT read-only from SPI.
module adxl_spi_responder #(
    parameter int unsigned  N_REG    = 64,
    parameter int unsigned  RO_LIMIT = 16,
    localparam int unsigned AW       = $clog2(N_REG)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          spi_sclk,
    input  logic          spi_mosi,
    input  logic          spi_ss_n,
    output logic          spi_miso,
    output logic          spi_miso_oe,
    input  logic          host_wr,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wr_data,
    output logic [7:0]    host_rd_data,
    output logic          spi_wr_valid,
    output logic [AW-1:0] spi_wr_addr,
    output logic [7:0]    spi_wr_data,
    output logic          busy
);

`ifdef SPI_RESP_RO_PROTECT_EN
    localparam bit RoProtect = 1'b1;
`else
    localparam bit RoProtect = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StWrData, StRdData, StIgnore} state_e;

    state_e        state_q, state_d;
    logic [2:0]    sclk_q, ss_q;
    logic [1:0]    mosi_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    rx_q, tx_q, rx_byte;
    logic [AW-1:0] ptr_q, addr_byte;
    logic          is_read_q, miso_q, wr_pend_q, wr_valid_q;
    logic [AW-1:0] wr_addr_q;
    logic [7:0]    wr_data_q, rd_data_q;
    logic [7:0]    regs_q [N_REG];
    logic          rise, fall, ss_start, desel, byte_done, ro_hit, commit;

    // Index [1] is the synchronized value, [2] the previous one for edge detection.
    assign rise      = sclk_q[1] & ~sclk_q[2];
    assign fall      = ~sclk_q[1] & sclk_q[2];
    assign ss_start  = ~ss_q[1] & ss_q[2];
    assign desel     = ss_q[1];
    assign byte_done = rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_q[6:0], mosi_q[1]};
    assign addr_byte = rx_byte[AW-1:0];
    assign ro_hit    = RoProtect && (32'(ptr_q) < RO_LIMIT);
    assign commit    = (state_q == StWrData) && byte_done && !ro_hit;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sclk_q <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            ss_q   <= {ss_q[1:0], spi_ss_n};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (desel) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: if (ss_start) state_d = StCmd;
                StCmd: begin
                    if (byte_done) begin
                        state_d = (rx_byte == 8'h0A || rx_byte == 8'h0B) ? StAddr : StIgnore;
                    end
                end
                StAddr: if (byte_done) state_d = is_read_q ? StRdData : StWrData;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt_q  <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            ptr_q      <= '0;
            is_read_q  <= 1'b0;
            miso_q     <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            // Commit is staged one cycle so the pulse trails the register update.
            wr_pend_q  <= commit;
            wr_valid_q <= wr_pend_q;
            if (commit) begin
                wr_addr_q <= ptr_q;
                wr_data_q <= rx_byte;
            end
            if (desel || state_q == StIdle) bit_cnt_q <= '0;
            else if (rise)                  bit_cnt_q <= bit_cnt_q + 3'd1;
            if (rise) rx_q <= rx_byte;
            if (state_q == StCmd && byte_done) is_read_q <= (rx_byte == 8'h0B);
            if (byte_done) begin
                case (state_q)
                    StAddr: begin
                        if (is_read_q) begin
                            tx_q  <= regs_q[addr_byte];
                            ptr_q <= addr_byte + AW'(1);
                        end else begin
                            ptr_q <= addr_byte;
                        end
                    end
                    StRdData: begin
                        tx_q  <= regs_q[ptr_q];
                        ptr_q <= ptr_q + AW'(1);
                    end
                    StWrData: ptr_q <= ptr_q + AW'(1);
                    default: ;
                endcase
            end else if (fall && state_q == StRdData) begin
                tx_q <= {tx_q[6:0], 1'b0};
            end
            if (state_q != StRdData || desel) miso_q <= 1'b0;
            else if (fall)                     miso_q <= tx_q[7];
        end
    end

    // SPI commit wins over a host write to the same address in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_REG; i++) regs_q[i] <= '0;
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < N_REG; i++) begin
                if (commit && ptr_q == AW'(i))              regs_q[i] <= rx_byte;
                else if (host_wr && host_addr == AW'(i))    regs_q[i] <= host_wr_data;
            end
            rd_data_q <= regs_q[host_addr];
        end
    end

    assign spi_miso     = miso_q;
    assign busy         = ~ss_q[1];
    assign spi_miso_oe  = ~ss_q[1];
    assign host_rd_data = rd_data_q;
    assign spi_wr_valid = wr_valid_q;
    assign spi_wr_addr  = wr_addr_q;
    assign spi_wr_data  = wr_data_q;

endmodule
